// File: rtl/pipeline_mem_arbiter_pkg.sv
// Shared definitions for the pipeline memory arbiter: FSM state encoding,
// requester port identifiers and small state-mapping helpers.
package riscv_mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACC_IF  = 3'd1,
    ACC_D   = 3'd2,
    DONE_IF = 3'd3,
    DONE_D  = 3'd4
  } arb_state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  // Access state entered when the given port wins arbitration.
  function automatic arb_state_e acc_state_of(input logic port);
    return (port == PORT_D) ? ACC_D : ACC_IF;
  endfunction

  // Completion state that follows a given access state.
  function automatic arb_state_e done_state_of(input arb_state_e acc);
    return (acc == ACC_D) ? DONE_D : DONE_IF;
  endfunction

endpackage

// File: rtl/pipeline_mem_arbiter_latency_timer.sv
// Down-counter timing one fixed-latency memory access. Loaded on grant,
// decremented while the access is in progress, flags done at zero.
module mem_arb_latency_timer #(
  parameter int unsigned CNT_W = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;

  // Load on grant, count down during the access, park at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/pipeline_mem_arbiter.sv
// Arbiter sharing one single-ported fixed-latency memory between the
// instruction-fetch port and the MEM-stage data port. Data has priority.
// Optional starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module pipeline_mem_arbiter
  import riscv_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy
);

  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  arb_state_e        r_state;
  logic              r_if_ack;
  logic              r_d_ack;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic w_idle;
  logic w_in_acc;
  logic w_grant;
  logic w_grant_port;
  logic w_done;

  assign w_idle   = (r_state == IDLE);
  assign w_in_acc = (r_state == ACC_IF) || (r_state == ACC_D);
  assign w_grant  = w_idle && (if_req || d_req);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [SW-1:0] r_starve;
  logic          w_force_if;

  assign w_force_if   = if_req && (r_starve == SW'(STARVE_LIMIT));
  assign w_grant_port = (d_req && !w_force_if) ? PORT_D : PORT_IF;

  // Count data grants that bypass a waiting fetch; clear once fetch is not waiting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_starve <= '0;
    end else if (w_grant) begin
      if ((w_grant_port == PORT_D) && if_req) begin
        r_starve <= r_starve + SW'(1);
      end else begin
        r_starve <= '0;
      end
    end
  end
`else
  assign w_grant_port = d_req ? PORT_D : PORT_IF;
`endif

  mem_arb_latency_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_grant),
    .i_dec      (w_in_acc),
    .i_load_val (CNT_W'(MEM_LATENCY - 1)),
    .o_done     (w_done)
  );

  // Arbitration FSM with registered memory-side and ack outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state  <= acc_state_of(w_grant_port);
            r_mem_en <= 1'b1;
            if (w_grant_port == PORT_D) begin
              r_mem_we    <= d_we;
              r_mem_addr  <= d_addr;
              r_mem_wdata <= d_wdata;
            end else begin
              r_mem_we    <= 1'b0;
              r_mem_addr  <= if_addr;
              r_mem_wdata <= '0;
            end
          end
        end
        ACC_IF, ACC_D: begin
          if (w_done) begin
            if (r_state == ACC_IF) begin
              r_if_rdata <= mem_rdata;
              r_if_ack   <= 1'b1;
            end else begin
              if (!r_mem_we) begin
                r_d_rdata <= mem_rdata;
              end
              r_d_ack <= 1'b1;
            end
            r_state     <= done_state_of(r_state);
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
          end
        end
        DONE_IF, DONE_D: begin
          r_if_ack <= 1'b0;
          r_d_ack  <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign if_ack    = r_if_ack;
  assign d_ack     = r_d_ack;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign stall_if  = if_req & ~r_if_ack;
  assign stall_mem = d_req & ~r_d_ack;
  assign busy      = !w_idle;

endmodule
